// File: rtl/module_lector_banco_if.sv
// Connection bundle between the register-file dump reader and its environment:
// dump control, register-file read port and the outgoing byte stream.
interface module_lector_banco_if #(
    parameter int N = 32,
    parameter int W = 32
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    logic          start;
    logic [AW-1:0] addr_rs;
    logic [W-1:0]  rs_data;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [1:0]    state;

    // Byte stream: a byte moves on every rising edge where out_valid and out_ready
    // are both 1; once raised, out_valid and out_data stay put until that happens.
    modport master (
        input  start, rs_data, out_ready,
        output addr_rs, out_data, out_valid, busy, done, state
    );

    modport slave (
        output start, rs_data, out_ready,
        input  addr_rs, out_data, out_valid, busy, done, state
    );
endinterface

// File: rtl/module_lector_banco.sv
// Reads register-file entries 0..N-1 on start and serialises each W-bit word
// as W/8 bytes, MSB byte first, over a valid/ready stream; read-only on the file.
module module_lector_banco #(
    parameter int N = 32,
    parameter int W = 32
) (
    input logic                  clk,
    input logic                  rst,
    module_lector_banco_if.master bus
);
    localparam int AW    = (N > 1) ? $clog2(N) : 1;
    localparam int BYTES = W / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    logic [AW-1:0]  addr;
    logic [BCW-1:0] byte_cnt;
    logic [W-1:0]   shreg;
    logic           out_valid_r;
    logic           busy_r;
    logic           done_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            byte_cnt    <= '0;
            shreg       <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        addr   <= '0;
                        busy_r <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    shreg       <= bus.rs_data;
                    byte_cnt    <= '0;
                    out_valid_r <= 1'b1;
                    state       <= SEND;
                end
                SEND: begin
                    // Without out_ready nothing moves, so out_data and addr_rs hold.
                    if (bus.out_ready) begin
                        shreg    <= shreg << 8;
                        byte_cnt <= byte_cnt + BCW'(1);
                        if (byte_cnt == BCW'(BYTES - 1)) begin
                            out_valid_r <= 1'b0;
                            if (addr == AW'(N - 1)) begin
                                done_r <= 1'b1;
                                state  <= DONE;
                            end else begin
                                addr  <= addr + AW'(1);
                                state <= LOAD;
                            end
                        end
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.addr_rs   = addr;
    assign bus.out_data  = shreg[W-1 -: 8];
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.state     = state;
endmodule

// File: tb/tb_module_lector_banco.sv
// Bench for the register-file dump reader: a 32x32 instance and a 4x8 instance,
// expected bytes queued at start, popped by negedge monitors on each transfer.
module tb_module_lector_banco;
    localparam int N1 = 32;
    localparam int W1 = 32;
    localparam int N2 = 4;
    localparam int W2 = 8;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    module_lector_banco_if #(.N(N1), .W(W1)) bus_a ();
    module_lector_banco_if #(.N(N2), .W(W2)) bus_b ();

    module_lector_banco #(.N(N1), .W(W1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
    module_lector_banco #(.N(N2), .W(W2)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

    // Register-file models answer the read port combinationally
    logic [W1-1:0] regs_a[N1];
    logic [W2-1:0] regs_b[N2];
    assign bus_a.rs_data = regs_a[bus_a.addr_rs];
    assign bus_b.rs_data = regs_b[bus_b.addr_rs];

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int pass_cnt = 0;
    int total_cnt = 0;
    int bytes_a = 0;
    int dones_a = 0;
    int done_cyc_a = 0;
    int bytes_b = 0;
    int dones_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // ---------------- monitors ----------------
    initial begin
        logic        stalled = 1'b0;
        logic        done_prev = 1'b0;
        logic [31:0] hold_d = '0;
        logic [31:0] hold_a = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled   = 1'b0;
                done_prev = 1'b0;
            end else begin
                if (stalled) begin
                    check("a_stall_data", bus_a.out_data, hold_d);
                    check("a_stall_addr", bus_a.addr_rs, hold_a);
                    check("a_stall_valid", bus_a.out_valid, 1);
                end
                if (bus_a.out_valid && bus_a.out_ready) begin
                    bytes_a++;
                    if (exp_a.size() == 0) begin
                        total_cnt++;
                        $display("FAIL a_extra_byte: actual=%0h required=none", bus_a.out_data);
                    end else begin
                        check("a_byte", bus_a.out_data, exp_a.pop_front());
                    end
                end
                stalled = bus_a.out_valid && !bus_a.out_ready;
                hold_d  = 32'(bus_a.out_data);
                hold_a  = 32'(bus_a.addr_rs);
                if (bus_a.done) begin
                    dones_a++;
                    done_cyc_a = cyc;
                    check("a_done_width", done_prev, 0);
                    check("a_done_q_empty", exp_a.size(), 0);
                end
                done_prev = bus_a.done;
            end
        end
    end

    initial begin
        logic done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_prev = 1'b0;
            end else begin
                if (bus_b.out_valid && bus_b.out_ready) begin
                    bytes_b++;
                    if (exp_b.size() == 0) begin
                        total_cnt++;
                        $display("FAIL b_extra_byte: actual=%0h required=none", bus_b.out_data);
                    end else begin
                        check("b_byte", bus_b.out_data, exp_b.pop_front());
                    end
                end
                if (bus_b.done) begin
                    dones_b++;
                    check("b_done_width", done_prev, 0);
                    check("b_done_q_empty", exp_b.size(), 0);
                end
                done_prev = bus_b.done;
            end
        end
    end

    // ---------------- reference model / drivers ----------------
    task automatic load_exp_a();
        for (int i = 0; i < N1; i++)
            for (int b = 0; b < W1 / 8; b++)
                exp_a.push_back(regs_a[i][W1-1-8*b -: 8]);
    endtask

    task automatic load_exp_b();
        for (int i = 0; i < N2; i++)
            for (int b = 0; b < W2 / 8; b++)
                exp_b.push_back(regs_b[i][W2-1-8*b -: 8]);
    endtask

    task automatic start_a(output int c0);
        @(posedge clk); #1;
        bus_a.start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        check("a_busy_in_load", bus_a.busy, 1);
        check("a_valid_in_load", bus_a.out_valid, 0);
    endtask

    task automatic run_a(input int pulse_at, input int stall_at, input bit rnd, output int c0);
        int  b0 = bytes_a;
        int  d0 = dones_a;
        int  n = 0;
        bit  stall_done = 1'b0;
        load_exp_a();
        start_a(c0);
        while (dones_a == d0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) check("a_first_valid", bus_a.out_valid, 1);
            bus_a.start = (pulse_at >= 0 && bytes_a - b0 == pulse_at);
            if (rnd) bus_a.out_ready = 1'($urandom_range(0, 1));
            if (stall_at >= 0 && !stall_done && bytes_a - b0 == stall_at && bus_a.out_valid) begin
                bus_a.out_ready = 1'b0;
                stall_done = 1'b1;
                repeat (3) begin
                    @(posedge clk); #1;
                    check("a_stall_c0", bus_a.out_data, 8'hC0);
                    check("a_stall_addr5", bus_a.addr_rs, 5);
                end
                bus_a.out_ready = 1'b1;
            end
        end
        bus_a.start = 1'b0;
        bus_a.out_ready = 1'b1;
        if (dones_a == d0) begin
            total_cnt++;
            $display("FAIL a_done_timeout: actual=no done required=done within 2000 cycles");
        end
        repeat (2) @(posedge clk);
        #1;
        check("a_done_count", dones_a - d0, 1);
        check("a_byte_count", bytes_a - b0, N1 * W1 / 8);
        check("a_queue_drained", exp_a.size(), 0);
        check("a_idle_busy", bus_a.busy, 0);
        check("a_idle_done", bus_a.done, 0);
    endtask

    task automatic run_b(input bit rnd);
        int b0 = bytes_b;
        int d0 = dones_b;
        int n = 0;
        load_exp_b();
        @(posedge clk); #1;
        bus_b.start = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        while (dones_b == d0 && n < 500) begin
            @(posedge clk); #1;
            n++;
            if (rnd) bus_b.out_ready = 1'($urandom_range(0, 1));
        end
        bus_b.out_ready = 1'b1;
        if (dones_b == d0) begin
            total_cnt++;
            $display("FAIL b_done_timeout: actual=no done required=done within 500 cycles");
        end
        repeat (2) @(posedge clk);
        #1;
        check("b_done_count", dones_b - d0, 1);
        check("b_byte_count", bytes_b - b0, N2 * W2 / 8);
        check("b_idle_busy", bus_b.busy, 0);
        check("b_queue_drained", exp_b.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        int b0;
        int d0;
        int n;
        rst = 1'b1;
        bus_a.start = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_b.start = 1'b0;
        bus_b.out_ready = 1'b1;
        for (int i = 0; i < N1; i++) regs_a[i] = 32'hA0B0C000 + 32'(i);
        for (int i = 0; i < N2; i++) regs_b[i] = 8'h10 + 8'(i);
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", bus_a.addr_rs, 0);
        check("rst_data", bus_a.out_data, 0);
        check("rst_valid", bus_a.out_valid, 0);
        check("rst_busy", bus_a.busy, 0);
        check("rst_done", bus_a.done, 0);
        check("rst_b_valid", bus_b.out_valid, 0);
        check("rst_b_busy", bus_b.busy, 0);
        rst = 1'b0;

        // full dump with a stray start at the 10th byte
        run_a(10, -1, 1'b0, c0);
        check("a_done_latency", done_cyc_a - c0, 161);

        // three-cycle stall on byte 2 of word 5
        run_a(-1, 22, 1'b0, c0);

        // 50% random out_ready, fixed and then random register contents
        run_a(-1, -1, 1'b1, c0);
        for (int i = 0; i < N1; i++) regs_a[i] = $urandom();
        run_a(-1, -1, 1'b1, c0);
        for (int i = 0; i < N1; i++) regs_a[i] = 32'hA0B0C000 + 32'(i);

        // reset during word 7 aborts without done
        b0 = bytes_a;
        d0 = dones_a;
        n = 0;
        load_exp_a();
        start_a(c0);
        while (bytes_a - b0 < 29 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_addr_word7", bus_a.addr_rs, 7);
        rst = 1'b1;
        #1;
        check("abort_valid", bus_a.out_valid, 0);
        check("abort_busy", bus_a.busy, 0);
        check("abort_done", bus_a.done, 0);
        check("abort_addr", bus_a.addr_rs, 0);
        exp_a.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_no_done", dones_a - d0, 0);
        run_a(-1, -1, 1'b0, c0);

        // small instance: fixed then random contents
        run_b(1'b0);
        for (int i = 0; i < N2; i++) regs_b[i] = 8'($urandom());
        run_b(1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
